key_matrix_scan: RTL
====================

Name: key_matrix_scan

Overview:
- Upstream feeder of the 8-digit seven-segment display controller: scans a 4x4 key matrix, debounces presses and builds the 32-bit packed-BCD word (8 digits) that the display controller shows.
- Digit keys shift into the word from the right. One key clears it. Each accepted press is also reported as a one-cycle event.
- Sits between the board keypad pins and the display controller's bcd8d input.

Parameters:
- SCAN_DIV, 50000, clock cycles each column is driven; must be at least 4.
- DEB_FRAMES, 5, consecutive identical full-matrix frames needed to accept a press or a release; must be at least 1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  reset, synchronous and active-high.
- key_row  input  4  matrix rows, active-high, asynchronous to clk; bit r is row r.
- key_col  output  4  column drive, one-hot, active-high; bit c is column c.
- key_code  output  4  code of the last accepted key, equal to 4*row + col.
- key_valid  output  1  one-cycle pulse per accepted press.
- bcd8d  output  32  packed BCD digits; [31:28] is the most significant digit, [3:0] the least.

Behaviour:
- Reset, checked on the clk edge while rst=1: key_col=4'b0001, key_code=0, key_valid=0, bcd8d=0. Reset also clears the dwell counter, column index, synchronizer, frame accumulator, debounce counter and FSM (state IDLE).
- Synchronizer: key_row passes through a 2-flop synchronizer. All logic below uses the synchronized rows.
- Scan:
  - A dwell counter counts 0..SCAN_DIV-1 and then wraps.
  - On the wrap, the column index advances 0→1→2→3→0, and key_col = 1 << index.
  - Frame = 4*SCAN_DIV cycles.
- Sampling:
  - On the dwell count SCAN_DIV-1 of each column, the synchronized rows are sampled for that column.
  - The frame accumulator counts asserted row bits across the 4 columns and keeps the code of the last one seen.
- Frame result, evaluated at the sample of column 3:
  - NONE when 0 bits were set.
  - SINGLE(code) when exactly 1 bit was set.
  - MULTI when 2 or more were set. MULTI is treated as NONE in IDLE and DEB, and as held in PRESSED.
  - The accumulator clears for the next frame.
- FSM, which advances only at frame end:
  - IDLE: SINGLE(k) → cand=k, cnt=1. If DEB_FRAMES=1 go straight to ACCEPT; else go to DEB.
  - DEB: SINGLE(cand) → cnt+1; when cnt reaches DEB_FRAMES, ACCEPT. Any other result → IDLE, cnt=0.
  - ACCEPT (action, not a state):
    - key_valid=1 for exactly one cycle, the cycle after the frame-end edge.
    - key_code=cand on the same edge.
    - bcd8d updates on the same edge.
    - Then go to PRESSED with cnt=0.
  - PRESSED: a NONE frame → cnt+1; when cnt reaches DEB_FRAMES, go to IDLE. Any non-NONE frame (same key, a different key, or MULTI) → cnt=0. A different key is never accepted until a full release.
- bcd8d update on ACCEPT:
  - cand 0..9: bcd8d <= {bcd8d[27:0], cand}. The top digit is discarded.
  - cand 4'hC: bcd8d <= 0.
  - Other codes (A, B, D, E, F): bcd8d unchanged, but key_valid and key_code are still updated.
- bcd8d always holds valid BCD digits only (0..9).
- key_code holds its value between accepts.
- Scanning runs continuously and is not stalled by the FSM.
- rst asserted in any state, including mid-frame or PRESSED: every output returns to its reset value on that edge. A key still held after reset goes through the full IDLE/DEB sequence again.

Test Plan:
All scenarios use SCAN_DIV=4 and DEB_FRAMES=2 (frame = 16 cycles).
1. Reset: hold rst=1 for 3 cycles, then release → key_col=0001, bcd8d=0, key_valid=0, key_code=0. key_col then steps 0010, 0100, 1000, 0001 every 4 cycles.
2. Hold row1 asserted whenever col3 is driven (key 7) for 6 frames → exactly one key_valid pulse, at the end of the 2nd qualifying frame. key_code=7, bcd8d=32'h00000007 in the pulse cycle. No further pulses while held.
3. Press and release keys 1..9 then 0, each held ≥3 frames and released ≥3 frames → 10 pulses; final bcd8d=32'h34567890.
4. Bounce: assert key 5 for 1 frame, release for 2 frames; repeat 4 times → no key_valid, bcd8d unchanged.
5. Keys 2 and 6 held together for 5 frames → no pulse. Then, from bcd8d=32'h00001234, press key C (row3, col0) → one pulse, key_code=C, bcd8d=0. Then press key A → one pulse, key_code=A, bcd8d stays 0.
6. Hold key 3 into PRESSED, assert rst for 1 cycle → all outputs reset at once. Key still held → a new pulse after 2 more qualifying frames, with bcd8d=32'h00000003.

Source files
------------

// File: rtl/key_matrix_scan.sv
`default_nettype none
// ============================================================================
// Module   : key_matrix_scan
// Brief    : 4x4 key matrix scanner with frame debounce; builds an 8-digit
//            packed-BCD word for the seven-segment display controller.
// Revision : 1.0 - initial release
// ============================================================================
module key_matrix_scan #(
    parameter int SCAN_DIV   = 50000,
    parameter int DEB_FRAMES = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key_row,
    output logic [3:0]  key_col,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic [31:0] bcd8d
);

    localparam int c_dwell_w = $clog2(SCAN_DIV);
    localparam int c_cnt_w   = $clog2(DEB_FRAMES + 1);

    localparam logic [c_dwell_w-1:0] c_dwell_last = c_dwell_w'(SCAN_DIV - 1);
    localparam logic [c_cnt_w-1:0]   c_deb        = c_cnt_w'(DEB_FRAMES);
    localparam logic [c_cnt_w-1:0]   c_cnt_one    = c_cnt_w'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DEB     = 2'd1,
        ST_PRESSED = 2'd2
    } state_t;

    logic [3:0]           r_row_meta;
    logic [3:0]           r_row_sync;
    logic [c_dwell_w-1:0] r_dwell;
    logic [1:0]           r_col_idx;
    logic [1:0]           r_acc_cnt;
    logic [3:0]           r_acc_code;
    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [3:0]           r_cand;
    logic                 r_key_valid;
    logic [3:0]           r_key_code;
    logic [31:0]          r_bcd;

    logic                 w_sample;
    logic                 w_frame_end;
    logic [2:0]           w_col_hits;
    logic [2:0]           w_total;
    logic [1:0]           w_acc_sat;
    logic [1:0]           w_row_idx;
    logic [3:0]           w_last_code;
    logic                 w_none;
    logic                 w_single;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [3:0]           w_cand_nxt;
    logic                 w_accept;
    logic [31:0]          w_bcd_nxt;

    assign key_col   = 4'b0001 << r_col_idx;
    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign bcd8d     = r_bcd;

    assign w_sample    = (r_dwell == c_dwell_last);
    assign w_frame_end = w_sample && (r_col_idx == 2'd3);

    // Hits in the column being sampled, folded into the running frame count
    assign w_col_hits = {2'b00, r_row_sync[0]} + {2'b00, r_row_sync[1]}
                      + {2'b00, r_row_sync[2]} + {2'b00, r_row_sync[3]};
    assign w_total    = {1'b0, r_acc_cnt} + w_col_hits;
    assign w_acc_sat  = (w_total >= 3'd2) ? 2'd2 : w_total[1:0];

    always_comb begin
        w_row_idx = 2'd0;
        if (r_row_sync[3]) begin
            w_row_idx = 2'd3;
        end else if (r_row_sync[2]) begin
            w_row_idx = 2'd2;
        end else if (r_row_sync[1]) begin
            w_row_idx = 2'd1;
        end
    end

    assign w_last_code = (w_col_hits != 3'd0) ? {w_row_idx, r_col_idx} : r_acc_code;
    assign w_none      = (w_total == 3'd0);
    assign w_single    = (w_total == 3'd1);

    // Scan timing, synchronizer and frame accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_meta <= 4'd0;
            r_row_sync <= 4'd0;
            r_dwell    <= '0;
            r_col_idx  <= 2'd0;
            r_acc_cnt  <= 2'd0;
            r_acc_code <= 4'd0;
        end else begin
            r_row_meta <= key_row;
            r_row_sync <= r_row_meta;
            if (w_sample) begin
                r_dwell   <= '0;
                r_col_idx <= r_col_idx + 2'd1;
                if (w_frame_end) begin
                    r_acc_cnt  <= 2'd0;
                    r_acc_code <= 4'd0;
                end else begin
                    r_acc_cnt  <= w_acc_sat;
                    r_acc_code <= w_last_code;
                end
            end else begin
                r_dwell <= r_dwell + 1'b1;
            end
        end
    end

    // Debounce FSM; MULTI frames fall out as "neither none nor single"
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cand_nxt  = r_cand;
        w_accept    = 1'b0;
        if (w_frame_end) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_single) begin
                        w_cand_nxt = w_last_code;
                        if (DEB_FRAMES == 1) begin
                            w_accept    = 1'b1;
                            w_state_nxt = ST_PRESSED;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = ST_DEB;
                            w_cnt_nxt   = c_cnt_one;
                        end
                    end
                end
                ST_DEB: begin
                    if (w_single && (w_last_code == r_cand)) begin
                        if ((r_cnt + c_cnt_one) == c_deb) begin
                            w_accept    = 1'b1;
                            w_state_nxt = ST_PRESSED;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + c_cnt_one;
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_PRESSED: begin
                    if (w_none) begin
                        if ((r_cnt + c_cnt_one) == c_deb) begin
                            w_state_nxt = ST_IDLE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + c_cnt_one;
                        end
                    end else begin
                        w_cnt_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_bcd_nxt = r_bcd;
        if (w_accept) begin
            if (w_cand_nxt <= 4'd9) begin
                w_bcd_nxt = {r_bcd[27:0], w_cand_nxt};
            end else if (w_cand_nxt == 4'hC) begin
                w_bcd_nxt = 32'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_cand      <= 4'd0;
            r_key_valid <= 1'b0;
            r_key_code  <= 4'd0;
            r_bcd       <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cand      <= w_cand_nxt;
            r_key_valid <= w_accept;
            r_bcd       <= w_bcd_nxt;
            if (w_accept) begin
                r_key_code <= w_cand_nxt;
            end
        end
    end

endmodule
`default_nettype wire
